// File: rtl/archon_debug_trace_buffer.sv
// Debug trace buffer: watches the CPU debug bus, turns qualifying events
// (flag rising edges, FSM state changes, entropy class changes) into
// timestamped records and queues them in a show-ahead FIFO. A shock event
// can arm a post-trigger window that freezes capture for post-mortem readout.
//
// Output handshake: out_valid is high whenever the FIFO holds at least one
// record and out_data is that head record (combinational). A record is
// consumed on any cycle where out_valid && out_ready; the next record
// appears at the head on the following cycle. out_valid never depends on
// out_ready.
module archon_debug_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [6:0]                event_mask,
  input  logic                      trigger_enable,
  input  logic                      clear_freeze,
  input  logic [3:0]                cpu_debug_pc,
  input  logic [2:0]                cpu_debug_instr_type,
  input  logic [7:0]                cpu_debug_entropy_log,
  input  logic [1:0]                cpu_debug_fsm_state,
  input  logic [1:0]                cpu_debug_classified_entropy,
  input  logic                      cpu_debug_stall,
  input  logic                      cpu_debug_flush,
  input  logic                      cpu_debug_lock,
  input  logic                      cpu_debug_hazard_flag,
  input  logic                      cpu_debug_shock_detected,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_W+30:0]          out_data,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic [7:0]                overflow_count,
  output logic                      frozen
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = TS_W + 31;

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [7:0] POST_LAST = 8'(POST_TRIG);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } trig_state_t;

  trig_state_t trig_state, trig_state_next;
  logic [7:0]  post_cnt, post_cnt_next;

  logic [TS_W-1:0] timestamp;

  logic       prev_stall, prev_flush, prev_lock, prev_hazard, prev_shock;
  logic [1:0] prev_fsm_state, prev_classified;

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  logic [6:0]       cause, qual;
  logic             event_valid, full, pop, push, drop;
  logic [REC_W-1:0] record;

  // Each cause compares the current bus against last cycle's sample.
  assign cause = {
    cpu_debug_classified_entropy != prev_classified,
    cpu_debug_fsm_state != prev_fsm_state,
    cpu_debug_shock_detected & ~prev_shock,
    cpu_debug_hazard_flag & ~prev_hazard,
    cpu_debug_lock & ~prev_lock,
    cpu_debug_flush & ~prev_flush,
    cpu_debug_stall & ~prev_stall
  };
  assign qual = cause & event_mask;

  assign event_valid = enable && (qual != 7'd0) && (trig_state != ST_FROZEN);
  assign full        = (count == CNT_FULL);
  assign pop         = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push        = event_valid && (!full || pop);
  assign drop        = event_valid && full && !pop;

  assign record = {
    timestamp, qual, cpu_debug_pc, cpu_debug_fsm_state,
    cpu_debug_classified_entropy, cpu_debug_entropy_log,
    cpu_debug_instr_type, cpu_debug_stall, cpu_debug_flush,
    cpu_debug_lock, cpu_debug_hazard_flag, cpu_debug_shock_detected
  };

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fill_level = count;
  assign frozen     = (trig_state == ST_FROZEN);

  // Previous-sample registers track the bus every cycle, even when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_stall      <= 1'b0;
      prev_flush      <= 1'b0;
      prev_lock       <= 1'b0;
      prev_hazard     <= 1'b0;
      prev_shock      <= 1'b0;
      prev_fsm_state  <= 2'd0;
      prev_classified <= 2'd0;
    end else begin
      prev_stall      <= cpu_debug_stall;
      prev_flush      <= cpu_debug_flush;
      prev_lock       <= cpu_debug_lock;
      prev_hazard     <= cpu_debug_hazard_flag;
      prev_shock      <= cpu_debug_shock_detected;
      prev_fsm_state  <= cpu_debug_fsm_state;
      prev_classified <= cpu_debug_classified_entropy;
    end
  end

  // Free-running timestamp, advanced only while capture is enabled.
  always_ff @(posedge clk) begin
    if (reset) timestamp <= '0;
    else if (enable) timestamp <= timestamp + TS_W'(1);
  end

  // Record storage; stale contents are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= record;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of records lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) overflow_count <= 8'd0;
    else if (drop && overflow_count != 8'hFF) overflow_count <= overflow_count + 8'd1;
  end

  // Trigger FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_state <= ST_ARMED;
      post_cnt   <= 8'd0;
    end else begin
      trig_state <= trig_state_next;
      post_cnt   <= post_cnt_next;
    end
  end

  // Trigger FSM next state: only accepted records advance the window.
  always_comb begin
    trig_state_next = trig_state;
    post_cnt_next   = post_cnt;
    case (trig_state)
      ST_ARMED: begin
        if (push && qual[4] && trigger_enable) begin
          post_cnt_next = 8'd1;
          if (POST_LAST == 8'd1) trig_state_next = ST_FROZEN;
          else trig_state_next = ST_POST;
        end
      end
      ST_POST: begin
        if (push) begin
          post_cnt_next = post_cnt + 8'd1;
          if (post_cnt + 8'd1 == POST_LAST) trig_state_next = ST_FROZEN;
        end
      end
      ST_FROZEN: begin
        if (clear_freeze) trig_state_next = ST_ARMED;
      end
      default: trig_state_next = ST_ARMED;
    endcase
  end

endmodule

// File: tb/tb_archon_debug_trace_buffer.sv
// Bench for archon_debug_trace_buffer: directed scenarios plus randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_archon_debug_trace_buffer;

  localparam int DEPTH     = 16;
  localparam int TS_W      = 16;
  localparam int POST_TRIG = 3;
  localparam int REC_W     = TS_W + 31;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [6:0]       event_mask;
  logic             trigger_enable;
  logic             clear_freeze;
  logic [3:0]       pc;
  logic [2:0]       instr_type;
  logic [7:0]       entropy_log;
  logic [1:0]       fsm_state;
  logic [1:0]       classified;
  logic             stall, flush, lock, hazard, shock;
  logic             out_valid;
  logic             out_ready;
  logic [REC_W-1:0] out_data;
  logic [4:0]       fill_level;
  logic [7:0]       overflow_count;
  logic             frozen;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  logic [REC_W-1:0] exp_q[$];
  logic [TS_W-1:0]  m_ts;
  logic             m_p_stall, m_p_flush, m_p_lock, m_p_hazard, m_p_shock;
  logic [1:0]       m_p_fsm, m_p_cls;
  int               m_ovf;
  bit               m_frozen, m_post;
  int               m_post_n;

  archon_debug_trace_buffer #(
    .DEPTH(DEPTH), .TS_W(TS_W), .POST_TRIG(POST_TRIG)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .enable                       (enable),
    .event_mask                   (event_mask),
    .trigger_enable               (trigger_enable),
    .clear_freeze                 (clear_freeze),
    .cpu_debug_pc                 (pc),
    .cpu_debug_instr_type         (instr_type),
    .cpu_debug_entropy_log        (entropy_log),
    .cpu_debug_fsm_state          (fsm_state),
    .cpu_debug_classified_entropy (classified),
    .cpu_debug_stall              (stall),
    .cpu_debug_flush              (flush),
    .cpu_debug_lock               (lock),
    .cpu_debug_hazard_flag        (hazard),
    .cpu_debug_shock_detected     (shock),
    .out_valid                    (out_valid),
    .out_ready                    (out_ready),
    .out_data                     (out_data),
    .fill_level                   (fill_level),
    .overflow_count               (overflow_count),
    .frozen                       (frozen)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  // Apply one clock edge of behaviour to the model, using the inputs as driven.
  task automatic model_step();
    logic [6:0] cause, qual;
    bit pop, ev, accept;
    if (reset) begin
      exp_q.delete();
      m_ts = '0; m_ovf = 0; m_frozen = 0; m_post = 0; m_post_n = 0;
      m_p_stall = 0; m_p_flush = 0; m_p_lock = 0; m_p_hazard = 0; m_p_shock = 0;
      m_p_fsm = 0; m_p_cls = 0;
      return;
    end
    cause[0] = stall & ~m_p_stall;
    cause[1] = flush & ~m_p_flush;
    cause[2] = lock & ~m_p_lock;
    cause[3] = hazard & ~m_p_hazard;
    cause[4] = shock & ~m_p_shock;
    cause[5] = (fsm_state != m_p_fsm);
    cause[6] = (classified != m_p_cls);
    qual   = cause & event_mask;
    pop    = (exp_q.size() != 0) && out_ready;
    ev     = enable && (qual != 0) && !m_frozen;
    accept = ev && ((exp_q.size() < DEPTH) || pop);
    if (pop) void'(exp_q.pop_front());
    if (accept)
      exp_q.push_back({m_ts, qual, pc, fsm_state, classified, entropy_log,
                       instr_type, stall, flush, lock, hazard, shock});
    if (ev && !accept && m_ovf < 255) m_ovf++;
    if (m_frozen) begin
      if (clear_freeze) m_frozen = 0;
    end else if (m_post) begin
      if (accept) begin
        m_post_n++;
        if (m_post_n == POST_TRIG) begin m_post = 0; m_frozen = 1; end
      end
    end else if (accept && qual[4] && trigger_enable) begin
      m_post_n = 1;
      if (POST_TRIG == 1) m_frozen = 1; else m_post = 1;
    end
    if (enable) m_ts = m_ts + 1'b1;
    m_p_stall = stall; m_p_flush = flush; m_p_lock = lock;
    m_p_hazard = hazard; m_p_shock = shock; m_p_fsm = fsm_state; m_p_cls = classified;
  endtask

  // Advance one cycle and scoreboard every output at the following negedge.
  task automatic tick();
    logic [REC_W-1:0] exp_data;
    model_step();
    @(posedge clk);
    @(negedge clk);
    exp_data = (exp_q.size() != 0) ? exp_q[0] : '0;
    compared += 5;
    if (out_valid !== (exp_q.size() != 0)) begin
      mismatched++; $display("FAIL sb_out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_q.size() != 0);
    end
    if (fill_level !== 5'(exp_q.size())) begin
      mismatched++; $display("FAIL sb_fill_level t=%0t got=%0d exp=%0d", $time, fill_level, exp_q.size());
    end
    if (out_data !== exp_data) begin
      mismatched++; $display("FAIL sb_out_data t=%0t got=%h exp=%h", $time, out_data, exp_data);
    end
    if (overflow_count !== 8'(m_ovf)) begin
      mismatched++; $display("FAIL sb_overflow t=%0t got=%0d exp=%0d", $time, overflow_count, m_ovf);
    end
    if (frozen !== m_frozen) begin
      mismatched++; $display("FAIL sb_frozen t=%0t got=%b exp=%b", $time, frozen, m_frozen);
    end
  endtask

  task automatic quiet_bus();
    enable = 0; event_mask = 0; trigger_enable = 0; clear_freeze = 0;
    pc = 0; instr_type = 0; entropy_log = 0; fsm_state = 0; classified = 0;
    stall = 0; flush = 0; lock = 0; hazard = 0; shock = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    quiet_bus();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    compared += 5;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin mismatched++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    if (fill_level !== 5'd0) begin mismatched++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
    if (overflow_count !== 8'd0) begin mismatched++; $display("FAIL reset_ovf got=%0d exp=0", overflow_count); end
    if (frozen !== 1'b0) begin mismatched++; $display("FAIL reset_frozen got=%b exp=0", frozen); end
  endtask

  task automatic test_single_stall();
    do_reset();
    enable = 1; event_mask = 7'h7F;
    for (int i = 0; i < 5; i++) tick();
    stall = 1;
    tick();
    compared += 4;
    if (out_valid !== 1'b1) begin mismatched++; $display("FAIL stall_valid got=%b exp=1", out_valid); end
    if (out_data[30:24] !== 7'h01) begin mismatched++; $display("FAIL stall_qual got=%h exp=01", out_data[30:24]); end
    if (out_data[46:31] !== 16'd5) begin mismatched++; $display("FAIL stall_ts got=%0d exp=5", out_data[46:31]); end
    if (fill_level !== 5'd1) begin mismatched++; $display("FAIL stall_fill got=%0d exp=1", fill_level); end
    out_ready = 1;
    tick();
    out_ready = 0;
    compared += 2;
    if (fill_level !== 5'd0) begin mismatched++; $display("FAIL stall_pop_fill got=%0d exp=0", fill_level); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL stall_pop_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_multi_cause();
    do_reset();
    enable = 1; classified = 1;
    tick();
    event_mask = 7'h7F; flush = 1; fsm_state = 2; classified = 3;
    pc = 4'hA; entropy_log = 8'h5C; instr_type = 3'd6;
    tick();
    compared += 3;
    if (fill_level !== 5'd1) begin mismatched++; $display("FAIL multi_fill got=%0d exp=1", fill_level); end
    if (out_data[30:24] !== 7'h62) begin mismatched++; $display("FAIL multi_qual got=%h exp=62", out_data[30:24]); end
    if (out_data[23:0] !== 24'hAB5CC8) begin mismatched++; $display("FAIL multi_fields got=%h exp=ab5cc8", out_data[23:0]); end
    out_ready = 1; event_mask = 0; flush = 0; fsm_state = 0; classified = 1;
    tick();
    out_ready = 0; event_mask = 7'h01; flush = 1; fsm_state = 2; classified = 3;
    tick();
    compared += 2;
    if (fill_level !== 5'd0) begin mismatched++; $display("FAIL masked_fill got=%0d exp=0", fill_level); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL masked_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1; event_mask = 7'h7F;
    for (int i = 0; i < 20; i++) begin fsm_state = fsm_state ^ 2'd1; tick(); end
    compared += 2;
    if (fill_level !== 5'd16) begin mismatched++; $display("FAIL ovf_fill got=%0d exp=16", fill_level); end
    if (overflow_count !== 8'd4) begin mismatched++; $display("FAIL ovf_count got=%0d exp=4", overflow_count); end
    out_ready = 1; fsm_state = fsm_state ^ 2'd1;
    tick();
    out_ready = 0;
    compared += 2;
    if (fill_level !== 5'd16) begin mismatched++; $display("FAIL full_pop_fill got=%0d exp=16", fill_level); end
    if (overflow_count !== 8'd4) begin mismatched++; $display("FAIL full_pop_ovf got=%0d exp=4", overflow_count); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin fsm_state = fsm_state ^ 2'd1; tick(); end
    compared += 1;
    if (overflow_count !== 8'd255) begin mismatched++; $display("FAIL sat_count got=%0d exp=255", overflow_count); end
  endtask

  task automatic test_trigger();
    do_reset();
    enable = 1; event_mask = 7'h7F; trigger_enable = 1; shock = 1;
    tick();
    trigger_enable = 0;
    for (int i = 0; i < 5; i++) begin fsm_state = fsm_state ^ 2'd1; tick(); end
    compared += 4;
    if (fill_level !== 5'd3) begin mismatched++; $display("FAIL trig_fill got=%0d exp=3", fill_level); end
    if (frozen !== 1'b1) begin mismatched++; $display("FAIL trig_frozen got=%b exp=1", frozen); end
    if (overflow_count !== 8'd0) begin mismatched++; $display("FAIL trig_ovf got=%0d exp=0", overflow_count); end
    if (out_data[28] !== 1'b1) begin mismatched++; $display("FAIL trig_head_shock got=%b exp=1", out_data[28]); end
    clear_freeze = 1;
    tick();
    clear_freeze = 0;
    compared += 2;
    if (frozen !== 1'b0) begin mismatched++; $display("FAIL clear_frozen got=%b exp=0", frozen); end
    if (fill_level !== 5'd3) begin mismatched++; $display("FAIL clear_fill got=%0d exp=3", fill_level); end
    fsm_state = fsm_state ^ 2'd1;
    tick();
    compared += 1;
    if (fill_level !== 5'd4) begin mismatched++; $display("FAIL after_clear_fill got=%0d exp=4", fill_level); end
  endtask

  task automatic test_reset_mid_post();
    do_reset();
    enable = 1; event_mask = 7'h7F; trigger_enable = 1; shock = 1;
    tick();
    fsm_state = 1;
    tick();
    compared += 2;
    if (fill_level !== 5'd2) begin mismatched++; $display("FAIL midpost_fill got=%0d exp=2", fill_level); end
    if (frozen !== 1'b0) begin mismatched++; $display("FAIL midpost_frozen got=%b exp=0", frozen); end
    reset = 1;
    tick();
    reset = 0;
    compared += 3;
    if (fill_level !== 5'd0) begin mismatched++; $display("FAIL rst_post_fill got=%0d exp=0", fill_level); end
    if (frozen !== 1'b0) begin mismatched++; $display("FAIL rst_post_frozen got=%b exp=0", frozen); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_post_valid got=%b exp=0", out_valid); end
    tick();
    compared += 2;
    if (out_data[46:31] !== 16'd0) begin mismatched++; $display("FAIL rst_post_ts got=%0d exp=0", out_data[46:31]); end
    if (out_data[30:24] !== 7'h30) begin mismatched++; $display("FAIL rst_post_qual got=%h exp=30", out_data[30:24]); end
    fsm_state = 2;
    tick();
    compared += 1;
    if (frozen !== 1'b0) begin mismatched++; $display("FAIL rearm_early got=%b exp=0", frozen); end
    fsm_state = 3;
    tick();
    compared += 1;
    if (frozen !== 1'b1) begin mismatched++; $display("FAIL rearm_freeze got=%b exp=1", frozen); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      enable         = ($urandom_range(0, 9) != 0);
      event_mask     = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : 7'h7F;
      trigger_enable = ($urandom_range(0, 3) == 0);
      clear_freeze   = ($urandom_range(0, 15) == 0);
      out_ready      = ($urandom_range(0, 2) == 0);
      pc             = 4'($urandom_range(0, 15));
      instr_type     = 3'($urandom_range(0, 7));
      entropy_log    = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) fsm_state = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) classified = 2'($urandom_range(0, 3));
      stall  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 5) == 0);
      lock   = ($urandom_range(0, 4) == 0);
      hazard = ($urandom_range(0, 4) == 0);
      shock  = ($urandom_range(0, 7) == 0);
      tick();
    end
    reset = 0;
  endtask

  initial begin
    quiet_bus();
    reset = 1;
    @(negedge clk);
    test_reset();
    test_single_stall();
    test_multi_cause();
    test_overflow();
    test_saturation();
    test_trigger();
    test_reset_mid_post();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
